// File: rtl/spike_window_player.sv
// -----------------------------------------------------------------------------
// spike_window_player
//
// Plays a LEN-slot temporal spike window out serially, one slot per cycle.
// Slot 0 is the earliest spike time. The block has an active window that is
// playing and a one-entry pending buffer, so a new window can be accepted
// while the current one plays. Back-to-back windows play with no gap. When
// the last slot of a window has played, a one-cycle result pulse reports:
// whether the window had any spike, the lowest spike slot, and the spike
// count.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_win     [0:LEN-1] window; bit t set = spike at slot t (bit 0 earliest)
//   in_valid   in_win is valid this cycle
//   in_ready   block can accept a window this cycle
//   spike      serial spike for the slot being played
//   t_now      index of the slot being played (0 when idle)
//   busy       a window is being played
//   res_valid  one-cycle pulse: first_hit/first_t/spike_cnt were updated
//   first_hit  finished window contained at least one spike
//   first_t    lowest set slot of the finished window (0 if none)
//   spike_cnt  number of set slots in the finished window
// -----------------------------------------------------------------------------
module spike_window_player #(
  parameter int LEN = 8,
  localparam int TW = $clog2(LEN),
  localparam int CW = $clog2(LEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [0:LEN-1]  in_win,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            spike,
  output logic [TW-1:0]   t_now,
  output logic            busy,
  output logic            res_valid,
  output logic            first_hit,
  output logic [TW-1:0]   first_t,
  output logic [CW-1:0]   spike_cnt
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   slot_q, slot_d;
  logic [0:LEN-1]  active_q, active_d;
  logic [0:LEN-1]  pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  logic            res_valid_q, res_valid_d;
  logic            first_hit_q, first_hit_d;
  logic [TW-1:0]   first_t_q, first_t_d;
  logic [CW-1:0]   spike_cnt_q, spike_cnt_d;

  logic            xfer;
  logic            last_slot;
  logic [TW-1:0]   low_idx;
  logic [CW-1:0]   pop_cnt;

  // Reset gates readiness so a window offered during reset is never taken.
  assign in_ready  = !pend_valid_q && !rst;
  assign xfer      = in_valid && in_ready;
  assign last_slot = (slot_q == TW'(LEN - 1));

  // Summary of the active window, used when its last slot is left.
  // Scanning downward leaves the lowest set index in low_idx.
  always_comb begin
    low_idx = '0;
    pop_cnt = '0;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (active_q[i]) begin
        low_idx = TW'(i);
      end
    end
    for (int i = 0; i < LEN; i++) begin
      pop_cnt = pop_cnt + CW'(active_q[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    res_valid_d  = 1'b0;
    first_hit_d  = first_hit_q;
    first_t_d    = first_t_q;
    spike_cnt_d  = spike_cnt_q;

    case (state_q)
      IDLE: begin
        // Idle accept goes straight to the active register.
        if (xfer) begin
          active_d = in_win;
          slot_d   = '0;
          state_d  = PLAY;
        end
      end

      PLAY: begin
        slot_d = slot_q + TW'(1);
        if (last_slot) begin
          res_valid_d = 1'b1;
          first_hit_d = |active_q;
          first_t_d   = low_idx;
          spike_cnt_d = pop_cnt;
          slot_d      = '0;
          if (pend_valid_q) begin
            // Pending window takes over with no bubble; the buffer frees up
            // unless a new transfer refills it in the same cycle.
            active_d     = pend_q;
            pend_valid_d = 1'b0;
            if (xfer) begin
              pend_d       = in_win;
              pend_valid_d = 1'b1;
            end
          end else if (xfer) begin
            // Window offered exactly on the last slot goes straight in.
            active_d = in_win;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          pend_d       = in_win;
          pend_valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      res_valid_q  <= 1'b0;
      first_hit_q  <= 1'b0;
      first_t_q    <= '0;
      spike_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      res_valid_q  <= res_valid_d;
      first_hit_q  <= first_hit_d;
      first_t_q    <= first_t_d;
      spike_cnt_q  <= spike_cnt_d;
    end
  end

  // Play outputs decode directly from registered state.
  assign busy      = (state_q == PLAY);
  assign spike     = busy && active_q[slot_q];
  assign t_now     = busy ? slot_q : '0;
  assign res_valid = res_valid_q;
  assign first_hit = first_hit_q;
  assign first_t   = first_t_q;
  assign spike_cnt = spike_cnt_q;

endmodule

// File: tb/tb_spike_window_player.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for spike_window_player (LEN = 8).
// Each accepted window appends its LEN expected (slot, spike) pairs to a play
// queue and its expected result to a result queue. A monitor on the falling
// edge pops and compares whenever the DUT is playing or reporting.
// -----------------------------------------------------------------------------
module tb_spike_window_player;

  localparam int LEN = 8;
  localparam int TW  = $clog2(LEN);
  localparam int CW  = $clog2(LEN + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [0:LEN-1]  in_win;
  logic            in_valid;
  logic            in_ready;
  logic            spike;
  logic [TW-1:0]   t_now;
  logic            busy;
  logic            res_valid;
  logic            first_hit;
  logic [TW-1:0]   first_t;
  logic [CW-1:0]   spike_cnt;

  spike_window_player #(.LEN(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_win    (in_win),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .spike     (spike),
    .t_now     (t_now),
    .busy      (busy),
    .res_valid (res_valid),
    .first_hit (first_hit),
    .first_t   (first_t),
    .spike_cnt (spike_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected play stream: entry = slot*2 + spike bit
  int play_q[$];
  // Expected results: hit*1000 + first*100 + count (small values, LEN=8)
  int res_q[$];
  int last_res = 0;
  bit res_due  = 1'b0;

  function automatic int model_result(input logic [0:LEN-1] w);
    int cnt = 0;
    int first = -1;
    for (int t = 0; t < LEN; t++) begin
      if (w[t]) begin
        cnt++;
        if (first < 0) first = t;
      end
    end
    if (first < 0) first = 0;
    return ((cnt > 0) ? 1000 : 0) + first * 100 + cnt;
  endfunction

  always @(negedge clk) begin
    int e;
    chk("in_ready", int'(in_ready), int'(!rst && (play_q.size() <= LEN)));
    chk("res_valid", int'(res_valid), int'(res_due));
    if (res_due) begin
      if (res_q.size() == 0) chk("res_queue_underflow", 1, 0);
      else last_res = res_q.pop_front();
    end
    res_due = 1'b0;
    chk("first_hit", int'(first_hit), last_res / 1000);
    chk("first_t",   int'(first_t),   (last_res / 100) % 10);
    chk("spike_cnt", int'(spike_cnt), last_res % 100);
    chk("busy", int'(busy), int'(play_q.size() > 0));
    if (play_q.size() > 0) begin
      e = play_q.pop_front();
      chk("spike", int'(spike), e % 2);
      chk("t_now", int'(t_now), e / 2);
      if (e / 2 == LEN - 1) res_due = 1'b1;
    end else begin
      chk("spike_idle", int'(spike), 0);
      chk("t_now_idle", int'(t_now), 0);
    end
    if (!rst && in_valid && in_ready) begin
      for (int t = 0; t < LEN; t++) play_q.push_back(t * 2 + int'(in_win[t]));
      res_q.push_back(model_result(in_win));
      $display("accept win=%b at %0t", in_win, $time);
    end
    if (rst) begin
      play_q.delete();
      res_q.delete();
      res_due  = 1'b0;
      last_res = 0;
    end
  end

  // Offer a window and hold in_valid until it is taken.
  task automatic send(input logic [0:LEN-1] w, input int gap);
    bit acc = 1'b0;
    int n = 0;
    in_win   = w;
    in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || play_q.size() > 0 || res_due) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("idle_timeout", 0, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [0:LEN-1] w;
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_win   = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Spikes at slots 1 and 6
    send(8'b0100_0010, 0);
    wait_idle();

    // Three back-to-back windows with in_valid held
    send(8'b1000_0001, 0);
    send(8'b0011_0000, 0);
    send(8'b0000_0100, 0);
    wait_idle();

    // All-zero then all-ones
    send(8'b0000_0000, 0);
    send(8'b1111_1111, 0);
    wait_idle();

    // New window offered exactly in the slot-7 cycle
    send(8'b0001_1000, 7);
    send(8'b1010_1010, 0);
    wait_idle();

    // Reset at slot 4 with a pending window held
    send(8'b1100_0011, 0);
    send(8'b0110_0110, 0);
    n = 0;
    while (t_now != TW'(4) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("slot4_timeout", 0, 1);
    in_win   = 8'b1111_0000;
    in_valid = 1'b1;
    pulse_rst();
    in_valid = 1'b0;
    wait_idle();

    // Randomized traffic with occasional resets
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0:       w = '0;
        1:       w = '1;
        default: w = LEN'($urandom);
      endcase
      send(w, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : 0);
      if ($urandom_range(0, 19) == 0) pulse_rst();
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
